// File: rtl/prbs7_rx.sv
// PRBS7 (x^7+x^6+1) receiver: self-synchronising lock, free-running check once locked,
// windowed loss-of-lock detection, and saturating error / sample counters.
module prbs7_rx #(
  parameter int LOCK_CNT = 16,
  parameter int WIN      = 128,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [7:0]  LOCK_V = 8'(LOCK_CNT);
  localparam logic [15:0] WIN_V  = 16'(WIN);
  localparam logic [15:0] THR_V  = 16'(LOSS_THR);

  state_t           r_state;
  logic [6:0]       r_s;
  logic [7:0]       r_mcnt;
  logic [15:0]      r_wcnt;
  logic [15:0]      r_ewin;
  logic             r_locked;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_bit_cnt;

  logic             w_p;
  logic             w_mis;
  logic             w_match;
  logic [7:0]       w_mcnt_nx;
  logic [15:0]      w_wcnt_nx;
  logic [15:0]      w_ewin_nx;

  // s[0] is the newest bit, so the tap pair x^7/x^6 lands on s[6]/s[5]
  assign w_p       = r_s[6] ^ r_s[5];
  assign w_mis     = din ^ w_p;
  assign w_match   = (r_s != 7'd0) && !w_mis;
  assign w_mcnt_nx = w_match ? r_mcnt + 8'd1 : 8'd0;
  assign w_wcnt_nx = r_wcnt + 16'd1;
  assign w_ewin_nx = r_ewin + {15'd0, w_mis};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SEARCH;
      r_s       <= 7'd0;
      r_mcnt    <= 8'd0;
      r_wcnt    <= 16'd0;
      r_ewin    <= 16'd0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge state
      // and the later clr_cnt assignment cleanly overrides same-edge increments.
      r_err <= 1'b0;
      if (en) begin
        if (r_state == SEARCH) begin
          r_s <= {r_s[5:0], din};
          if (w_mcnt_nx == LOCK_V) begin
            r_state  <= LOCKED;
            r_locked <= 1'b1;
            r_mcnt   <= 8'd0;
          end else begin
            r_mcnt <= w_mcnt_nx;
          end
        end else begin
          // Locked: regenerate from the local state so line errors cannot corrupt it
          r_s   <= {r_s[5:0], w_p};
          r_err <= w_mis;
          if (w_mis && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
          if (r_bit_cnt != '1)            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          if (w_ewin_nx == THR_V) begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
            r_mcnt   <= 8'd0;
            r_wcnt   <= 16'd0;
            r_ewin   <= 16'd0;
          end else if (w_wcnt_nx == WIN_V) begin
            r_wcnt <= 16'd0;
            r_ewin <= 16'd0;
          end else begin
            r_wcnt <= w_wcnt_nx;
            r_ewin <= w_ewin_nx;
          end
        end
      end
      if (clr_cnt) begin
        r_err_cnt <= '0;
        r_bit_cnt <= '0;
      end
    end
  end

  assign locked  = r_locked;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;
  assign bit_cnt = r_bit_cnt;

endmodule

// File: doc/prbs7_rx.md
PRBS7_RX -- requirements
Module: prbs7_rx

Interface
REQ-001 Parameter LOCK_CNT, default 16, SHALL set the consecutive matched samples required to lock (range 1..255).
REQ-002 Parameter WIN, default 128, SHALL set the error-monitor window length in valid samples while locked (range 2..65535).
REQ-003 Parameter LOSS_THR, default 8, SHALL set the errors within one window that force loss of lock (range 1..WIN).
REQ-004 Parameter CNT_W, default 16, SHALL set the width of err_cnt and bit_cnt.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 din  input  1  SHALL be the sliced line sample (comparator output at the far end of the channel under test).
REQ-008 en  input  1  SHALL qualify din; the block SHALL ignore din when en=0.
REQ-009 clr_cnt  input  1  SHALL synchronously clear err_cnt and bit_cnt.
REQ-010 locked  output  1  SHALL be high while in state LOCKED.
REQ-011 err  output  1  SHALL be a one-cycle pulse per mismatched valid sample in LOCKED.
REQ-012 err_cnt  output  CNT_W  SHALL be the saturating count of errors while locked.
REQ-013 bit_cnt  output  CNT_W  SHALL be the saturating count of valid samples checked while locked.

Function
REQ-014 Sequence SHALL be PRBS7 (x^7+x^6+1): state s[6:0], s[0] newest bit, predicted bit p = s[6] XOR s[5].
REQ-015 The FSM SHALL have exactly two states: SEARCH and LOCKED.
REQ-016 SEARCH, valid sample: s <= {s[5:0], din} (self-synchronising load).
REQ-017 SEARCH, valid sample with s != 0 and din == p: match counter mcnt increments; any other valid sample SHALL set mcnt to 0.
REQ-018 When a valid sample brings mcnt to LOCK_CNT, the FSM SHALL enter LOCKED on that edge; locked goes high in the following cycle.
REQ-019 LOCKED, valid sample: s <= {s[5:0], p} (free-running; line errors SHALL NOT corrupt s).
REQ-020 LOCKED, valid sample with din != p: err pulses high for exactly that cycle, err_cnt and the window error counter ewin each increment.
REQ-021 LOCKED, every valid sample SHALL increment bit_cnt and the window sample counter wcnt.
REQ-022 The increment of ewin on a sample SHALL be evaluated before the window-end check of that sample.
REQ-023 If ewin reaches LOSS_THR, the FSM SHALL return to SEARCH on that edge with mcnt=0, wcnt=0, ewin=0; s SHALL retain its value.
REQ-024 When wcnt reaches WIN without loss of lock, wcnt and ewin SHALL both reset to 0 on that edge.
REQ-025 err_cnt and bit_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-026 err_cnt and bit_cnt SHALL hold their values in SEARCH.
REQ-027 clr_cnt SHALL take priority: same-edge increments are discarded and both counters read 0.
REQ-028 With en=0 every register SHALL hold and err SHALL be 0.
REQ-029 An all-zero input stream SHALL never lock (s stays 0, mcnt stays 0).

Reset
REQ-030 rst=1 SHALL immediately set state SEARCH, s=0, mcnt=0, wcnt=0, ewin=0, err_cnt=0, bit_cnt=0, locked=0, err=0, independent of clk.
REQ-031 Reset asserted mid-lock or mid-window SHALL discard all progress; after release, lock SHALL be reacquired from scratch.

Verification
REQ-032 Clean PRBS7 stream, en=1 continuously, from reset -> locked high no later than the cycle after the 23rd valid sample; err never pulses; err_cnt=0.
REQ-033 Locked, one bit of din inverted -> exactly one err pulse on that sample's cycle; err_cnt=1; locked stays high; subsequent samples match.
REQ-034 Locked, 8 bit errors injected within one 128-sample window -> locked drops on the 8th error's edge; relock after at most 16 further clean samples.
REQ-035 Locked, 7 errors in window N and 7 in window N+1 -> locked never drops; err_cnt=14.
REQ-036 CNT_W=4, locked, 20 errors spread over separate windows -> err_cnt saturates at 15; clr_cnt coincident with an error -> err_cnt=0.
REQ-037 All-zero din for 500 samples, then en toggled randomly on a clean stream -> no lock during zeros; lock and counts equal those of the en-gapless run.
